// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Widths here are only defaults; every module keeps its own parameters.
package rf_pkg;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;
   localparam int RF_NUM_RD = 2;
   localparam int RF_NUM_WR = 2;
   localparam int RF_BYTES  = RF_DATA_W / 8;
   localparam int RF_ZERO_ADDR = 0;

   function automatic int byte_count(input int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Decode/writeback side bus of the register file: read, write, reserve and debug taps.
// The core (or bench) drives it through master; the register file consumes it through slave.
interface register_file_mp_if
   import rf_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_RD = RF_NUM_RD,
   parameter int NUM_WR = RF_NUM_WR
);

   localparam int BYTES = byte_count(DATA_W);

   logic [NUM_RD-1:0]        rd_en;
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;

   logic [NUM_WR-1:0]        wr_en;
   logic [NUM_WR*ADDR_W-1:0] wr_addr;
   logic [NUM_WR*BYTES-1:0]  wr_be;
   logic [NUM_WR*DATA_W-1:0] wr_data;

   logic                     rsv_en;
   logic [ADDR_W-1:0]        rsv_addr;

   logic [ADDR_W-1:0]        dbg_addr;
   logic [DATA_W-1:0]        dbg_data;
   logic [2**ADDR_W-1:0]     busy_vec;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data,
             rsv_en, rsv_addr, dbg_addr,
      input  rd_data, rd_busy, dbg_data, busy_vec
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data,
             rsv_en, rsv_addr, dbg_addr,
      output rd_data, rd_busy, dbg_data, busy_vec
   );

endinterface

// File: rtl/rf_bypass_mux.sv
// Per-byte merge of all write ports that target one address onto a base value.
// Later ports overwrite earlier ones, so the highest-index enabled port owns each byte.
module rf_bypass_mux
   import rf_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_WR = RF_NUM_WR
) (
   input  logic [ADDR_W-1:0]               addr,
   input  logic [DATA_W-1:0]               base,
   input  logic [NUM_WR-1:0]               wr_en,
   input  logic [NUM_WR*ADDR_W-1:0]        wr_addr,
   input  logic [NUM_WR*(DATA_W/8)-1:0]    wr_be,
   input  logic [NUM_WR*DATA_W-1:0]        wr_data,
   output logic [DATA_W-1:0]               merged,
   output logic                            hit
);

   localparam int BYTES = byte_count(DATA_W);

   // hit ignores byte enables: a write with no bytes still retires the producer
   always_comb begin
      merged = base;
      hit    = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
         if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == addr)) begin
            hit = 1'b1;
            for (int b = 0; b < BYTES; b++) begin
               if (wr_be[p*BYTES + b]) begin
                  merged[b*8 +: 8] = wr_data[p*DATA_W + b*8 +: 8];
               end
            end
         end
      end
   end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with byte-enable writes, read-during-write bypass,
// optional hardwired zero register and a busy scoreboard for out-of-order writeback.
module register_file_mp
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = RF_NUM_RD,
   parameter int NUM_WR   = RF_NUM_WR,
   parameter int ZERO_REG = 1
) (
   input logic               CLOCK_50,
   input logic               Rest,
   register_file_mp_if.slave bus
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_ADDR);

   logic [DATA_W-1:0] regs      [DEPTH];
   logic [DATA_W-1:0] regs_next [DEPTH];
   logic [DEPTH-1:0]  wr_hit;
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_next;

   logic [DATA_W-1:0]        rd_val [NUM_RD];
   logic [NUM_RD-1:0]        rd_busy_next;
   logic [NUM_RD*DATA_W-1:0] rd_data_q;
   logic [NUM_RD-1:0]        rd_busy_q;

   // Every row computes its own post-write value; the zero row is pinned to 0
   for (genvar r = 0; r < DEPTH; r++) begin : g_row
      logic [DATA_W-1:0] merged;

      rf_bypass_mux #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NUM_WR (NUM_WR)
      ) u_wr_merge (
         .addr    (ADDR_W'(r)),
         .base    (regs[r]),
         .wr_en   (bus.wr_en),
         .wr_addr (bus.wr_addr),
         .wr_be   (bus.wr_be),
         .wr_data (bus.wr_data),
         .merged  (merged),
         .hit     (wr_hit[r])
      );

      assign regs_next[r] = ((ZERO_REG != 0) && (r == 0)) ? '0 : merged;
   end

   // Clear on write, then set on reserve, so a same-cycle reserve keeps the new producer
   always_comb begin
      busy_next = busy & ~wr_hit;
      if (bus.rsv_en) begin
         busy_next[bus.rsv_addr] = 1'b1;
      end
      if (ZERO_REG != 0) begin
         busy_next[0] = 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] merged;
      logic              hit;
      logic              is_zero;
      logic              rsv_hit;

      assign addr    = bus.rd_addr[i*ADDR_W +: ADDR_W];
      assign is_zero = (ZERO_REG != 0) && (addr == ZERO_ADDR);
      assign rsv_hit = bus.rsv_en && (bus.rsv_addr == addr);

      rf_bypass_mux #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .NUM_WR (NUM_WR)
      ) u_rd_bypass (
         .addr    (addr),
         .base    (regs[addr]),
         .wr_en   (bus.wr_en),
         .wr_addr (bus.wr_addr),
         .wr_be   (bus.wr_be),
         .wr_data (bus.wr_data),
         .merged  (merged),
         .hit     (hit)
      );

      assign rd_val[i]       = is_zero ? '0 : merged;
      assign rd_busy_next[i] = is_zero ? 1'b0 : ((busy[addr] & ~hit) | rsv_hit);
   end

   // Array, scoreboard and read registers all clear together on reset
   always_ff @(posedge CLOCK_50 or posedge Rest) begin
      if (Rest) begin
         for (int r = 0; r < DEPTH; r++) begin
            regs[r] <= '0;
         end
         busy      <= '0;
         rd_data_q <= '0;
         rd_busy_q <= '0;
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            regs[r] <= regs_next[r];
         end
         busy <= busy_next;
         for (int i = 0; i < NUM_RD; i++) begin
            if (bus.rd_en[i]) begin
               rd_data_q[i*DATA_W +: DATA_W] <= rd_val[i];
               rd_busy_q[i]                  <= rd_busy_next[i];
            end
         end
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_busy  = rd_busy_q;
   assign bus.busy_vec = busy;
   assign bus.dbg_data = regs[bus.dbg_addr];

endmodule

// File: tb/tb_register_file_mp.sv
// Directed plus randomized checks of register_file_mp against an array/bit-vector model
// that applies writes port by port, clears then sets busy bits, and reads the result.
module tb_register_file_mp;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NUM_RD = 2;
   localparam int NUM_WR = 2;
   localparam int DEPTH  = 32;

   logic CLOCK_50;
   logic Rest;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_regs [DEPTH];
   logic [31:0] m_busy;
   logic [31:0] m_rd_data [NUM_RD];
   logic        m_rd_busy [NUM_RD];

   register_file_mp_if #(
      .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_RD (NUM_RD), .NUM_WR (NUM_WR)
   ) bus ();

   register_file_mp #(
      .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_RD (NUM_RD), .NUM_WR (NUM_WR), .ZERO_REG (1)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .Rest     (Rest),
      .bus      (bus)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #10 CLOCK_50 = ~CLOCK_50;
   end

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < DEPTH; r++) m_regs[r] = '0;
      m_busy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         m_rd_data[i] = '0;
         m_rd_busy[i] = 1'b0;
      end
   endtask

   task automatic idle();
      bus.rd_en = '0; bus.rd_addr = '0;
      bus.wr_en = '0; bus.wr_addr = '0; bus.wr_be = '0; bus.wr_data = '0;
      bus.rsv_en = 1'b0; bus.rsv_addr = '0;
      bus.dbg_addr = '0;
   endtask

   task automatic set_write(input int p, input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
      bus.wr_en[p]           = 1'b1;
      bus.wr_addr[p*5 +: 5]  = a;
      bus.wr_be[p*4 +: 4]    = be;
      bus.wr_data[p*32 +: 32] = d;
   endtask

   task automatic set_read(input int i, input logic [4:0] a);
      bus.rd_en[i]          = 1'b1;
      bus.rd_addr[i*5 +: 5] = a;
   endtask

   // Advance the model by one edge using the currently driven inputs, then clock the DUT
   task automatic apply_stimulus();
      for (int p = 0; p < NUM_WR; p++) begin
         int a;
         a = int'(bus.wr_addr[p*5 +: 5]);
         if (bus.wr_en[p] && a != 0) begin
            for (int b = 0; b < 4; b++)
               if (bus.wr_be[p*4 + b]) m_regs[a][b*8 +: 8] = bus.wr_data[p*32 + b*8 +: 8];
            m_busy[a] = 1'b0;
         end
      end
      if (bus.rsv_en && bus.rsv_addr != 0) m_busy[bus.rsv_addr] = 1'b1;
      for (int i = 0; i < NUM_RD; i++) begin
         if (bus.rd_en[i]) begin
            m_rd_data[i] = m_regs[bus.rd_addr[i*5 +: 5]];
            m_rd_busy[i] = m_busy[bus.rd_addr[i*5 +: 5]];
         end
      end
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check_output(input string tag);
      for (int i = 0; i < NUM_RD; i++) begin
         check($sformatf("%s.rd_data%0d", tag, i), 64'(bus.rd_data[i*32 +: 32]), 64'(m_rd_data[i]));
         check($sformatf("%s.rd_busy%0d", tag, i), 64'(bus.rd_busy[i]), 64'(m_rd_busy[i]));
      end
      check({tag, ".busy_vec"}, 64'(bus.busy_vec), 64'(m_busy));
      check({tag, ".dbg_data"}, 64'(bus.dbg_data), 64'(m_regs[bus.dbg_addr]));
   endtask

   initial begin
      model_reset();
      idle();
      Rest = 1'b1;
      repeat (2) @(posedge CLOCK_50);
      #1;
      check("reset_busy_vec", 64'(bus.busy_vec), 64'h0);
      Rest = 1'b0;

      // Reset then read registers 1 and 2
      set_read(0, 5'd1); set_read(1, 5'd2);
      apply_stimulus();
      check_output("reset_read");

      // Basic write followed by a read and debug tap
      idle();
      set_write(0, 5'd1, 4'hF, 32'h0000_0001);
      apply_stimulus();
      idle();
      set_read(0, 5'd1); bus.dbg_addr = 5'd1;
      apply_stimulus();
      check_output("basic");
      check("basic_const", 64'(bus.rd_data[31:0]), 64'h0000_0001);
      check("basic_dbg_const", 64'(bus.dbg_data), 64'h0000_0001);

      // Two ports hit addr 2 in one cycle; port 1 owns the low two bytes
      idle();
      set_write(0, 5'd2, 4'hF, 32'h1122_3344);
      set_write(1, 5'd2, 4'b0011, 32'hAABB_CCDD);
      set_read(0, 5'd2); bus.dbg_addr = 5'd2;
      apply_stimulus();
      check_output("bypass");
      check("bypass_const", 64'(bus.rd_data[31:0]), 64'h1122_CCDD);

      // Writes and reserves to register 0 are dropped
      idle();
      set_write(0, 5'd0, 4'hF, 32'hFFFF_FFFF);
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd0;
      set_read(1, 5'd0);
      apply_stimulus();
      check_output("zero_same_cycle");
      idle();
      set_read(0, 5'd0);
      apply_stimulus();
      check_output("zero");
      check("zero_const", 64'(bus.rd_data[31:0]), 64'h0);
      check("zero_busy_const", 64'(bus.busy_vec[0]), 64'h0);

      // Scoreboard: reserve, byte-less write clears, reserve+write keeps busy
      idle();
      set_write(0, 5'd5, 4'hF, 32'hCAFE_0005);
      apply_stimulus();
      idle();
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd5;
      apply_stimulus();
      check("sb_rsv_const", 64'(bus.busy_vec[5]), 64'h1);
      idle();
      set_read(0, 5'd5);
      apply_stimulus();
      check_output("sb_read");
      check("sb_rd_busy_const", 64'(bus.rd_busy[0]), 64'h1);
      idle();
      set_write(1, 5'd5, 4'h0, 32'hDEAD_BEEF);
      set_read(0, 5'd5); bus.dbg_addr = 5'd5;
      apply_stimulus();
      check_output("sb_clear");
      check("sb_clear_data_const", 64'(bus.rd_data[31:0]), 64'hCAFE_0005);
      check("sb_clear_busy_const", 64'(bus.busy_vec[5]), 64'h0);
      idle();
      set_write(0, 5'd5, 4'hF, 32'h5555_AAAA);
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd5;
      set_read(1, 5'd5);
      apply_stimulus();
      check_output("sb_rsv_wr");
      check("sb_rsv_wr_const", 64'(bus.busy_vec[5]), 64'h1);

      // Reset asserted between edges while addr 3 is being written
      idle();
      set_write(0, 5'd3, 4'hF, 32'h3333_3333);
      bus.rsv_en = 1'b1; bus.rsv_addr = 5'd3;
      set_read(0, 5'd3); bus.dbg_addr = 5'd3;
      apply_stimulus();
      set_write(1, 5'd3, 4'hF, 32'h4444_4444);
      #5;
      Rest = 1'b1;
      #1;
      model_reset();
      check_output("mid_reset");
      check("mid_reset_dbg_const", 64'(bus.dbg_data), 64'h0);
      @(posedge CLOCK_50);
      #1;
      idle();
      Rest = 1'b0;
      set_read(0, 5'd3); bus.dbg_addr = 5'd3;
      apply_stimulus();
      check_output("post_reset");

      // Random traffic on a narrow address range to provoke collisions
      for (int n = 0; n < 300; n++) begin
         idle();
         for (int p = 0; p < NUM_WR; p++) begin
            if ($urandom_range(0, 2) != 0)
               set_write(p, 5'($urandom_range(0, 7)), 4'($urandom), $urandom);
         end
         for (int i = 0; i < NUM_RD; i++) begin
            bus.rd_en[i] = 1'($urandom);
            bus.rd_addr[i*5 +: 5] = 5'($urandom_range(0, 7));
         end
         bus.rsv_en   = ($urandom_range(0, 3) == 0);
         bus.rsv_addr = 5'($urandom_range(0, 7));
         bus.dbg_addr = 5'($urandom_range(0, 7));
         apply_stimulus();
         check_output($sformatf("rand%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
